proc_exec_ctrl: RTL and testbench
=================================

PROC_EXEC_CTRL -- requirements
Module: proc_exec_ctrl

Interface
REQ-001 The block SHALL have parameter INST_WIDTH, default 16, giving the width of pc, bp_addr and inst.
REQ-002 The block SHALL have parameter HALT_INST, default 16'hFFFF, the instruction encoding that halts the core.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, the flop depth of the switch synchronizers.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 run_sw  in  1  level switch requesting continuous execution; asynchronous to clk.
REQ-007 step_sw  in  1  switch; each rising edge requests one instruction; asynchronous to clk.
REQ-008 bp_en  in  1  breakpoint enable.
REQ-009 bp_addr  in  INST_WIDTH  breakpoint PC value.
REQ-010 pc  in  INST_WIDTH  current PC of the single-cycle core.
REQ-011 inst  in  INST_WIDTH  instruction currently fetched at pc.
REQ-012 cpu_en  out  1  when 1, the core commits this cycle (PC update, register write, RAM write); when 0, the core holds.
REQ-013 halted  out  1  high while in HALT.
REQ-014 state  out  2  current state encoding.
REQ-015 inst_count  out  16  count of committed instructions.

Function
REQ-016 run_sw and step_sw SHALL each pass through a SYNC_STAGES-flop synchronizer (run_s, step_s) before use; step rising edge = step_s 1 with previous-cycle step_s 0.
REQ-017 States SHALL be IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
REQ-018 cpu_en SHALL be combinational from state, run_s, pc, inst, bp_en, bp_addr, bp_skip; no registered delay, because the core commits in the same cycle.
REQ-019 Halt condition: inst == HALT_INST; breakpoint hit: bp_en=1, pc == bp_addr, bp_skip=0.
REQ-020 IDLE: cpu_en=0; run_s=1 -> RUN; else step edge -> STEP; else stay; run_s has priority over a simultaneous step edge.
REQ-021 RUN, priority order: halt condition -> cpu_en=0, next HALT; else breakpoint hit -> cpu_en=0, next IDLE, set bp_skip; else run_s=0 -> cpu_en=0, next IDLE; else cpu_en=1, stay RUN.
REQ-022 STEP: halt condition -> cpu_en=0, next HALT; else cpu_en=1 for exactly this one cycle, next IDLE; breakpoints are ignored in STEP.
REQ-023 HALT: cpu_en=0, halted=1; exit only via rst; switch activity is ignored.
REQ-024 bp_skip SHALL be set on a breakpoint stop and cleared on the next cycle with cpu_en=1, so a resume from a breakpoint commits that instruction once.
REQ-025 inst_count SHALL increment by 1 on every clock edge where cpu_en=1 and saturate at 16'hFFFF.
REQ-026 Latency: a run_sw or step_sw change SHALL affect state no earlier than SYNC_STAGES+1 clk edges after it is applied.
REQ-027 halted SHALL equal (state == HALT); state SHALL be the registered state.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, cpu_en=0, halted=0, inst_count=0, bp_skip=0, and all synchronizer and edge flops to 0, independent of clk.
REQ-029 Reset deasserted mid-RUN SHALL return to IDLE and require a fresh run_s=1 observation to restart.
REQ-030 A step_sw held high through reset release SHALL NOT produce a step edge.

Verification
REQ-031 Reset, run_sw=1, inst never HALT_INST, bp_en=0 -> RUN after 3 edges, cpu_en=1 every cycle thereafter, inst_count=10 after 10 RUN cycles.
REQ-032 In IDLE, pulse step_sw 0->1 three times, separated -> exactly 3 single cycles of cpu_en=1, inst_count=3, state back to IDLE each time.
REQ-033 RUN with bp_en=1, bp_addr=16'h0004, pc reaching 4 -> cpu_en=0 that cycle, state IDLE; one step edge -> cpu_en=1 at pc=4, no re-hit.
REQ-034 RUN, inst=16'hFFFF -> cpu_en=0, next state HALT, halted=1; toggling run_sw/step_sw keeps HALT; rst returns to IDLE with inst_count=0.
REQ-035 Preload inst_count to 16'hFFFE via 16'hFFFE commits, then run 5 more cycles -> inst_count holds 16'hFFFF.
REQ-036 Assert rst asynchronously between clk edges during RUN -> cpu_en and inst_count drop to 0 before the next edge.

Source files
------------

// File: rtl/proc_exec_ctrl.sv
// -----------------------------------------------------------------------------
// proc_exec_ctrl
// Execution controller for a single-cycle core. It decides, cycle by cycle,
// whether the core commits (cpu_en_o) based on a run switch, a single-step
// switch, a PC breakpoint and a halt instruction.
//
// Ports
//   clk_i         : single clock, rising edge
//   rst_i         : asynchronous, active-high reset
//   run_sw_i      : level switch requesting continuous execution (async to clk)
//   step_sw_i     : each rising edge requests one instruction (async to clk)
//   bp_en_i       : breakpoint enable
//   bp_addr_i     : breakpoint PC value
//   pc_i          : current PC of the core
//   inst_i        : instruction fetched at pc_i
//   cpu_en_o      : core commits this cycle when 1 (combinational)
//   halted_o      : high while in HALT
//   state_o       : registered state (IDLE=00, RUN=01, STEP=10, HALT=11)
//   inst_count_o  : saturating count of committed instructions
//
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module proc_exec_ctrl #(
    parameter int                    INST_WIDTH  = 16,
    parameter logic [INST_WIDTH-1:0] HALT_INST   = 16'hFFFF,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_sw_i,
    input  logic                  step_sw_i,
    input  logic                  bp_en_i,
    input  logic [INST_WIDTH-1:0] bp_addr_i,
    input  logic [INST_WIDTH-1:0] pc_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    output logic                  cpu_en_o,
    output logic                  halted_o,
    output logic [1:0]            state_o,
    output logic [15:0]           inst_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    logic [SYNC_STAGES-1:0] run_sync_q;
    logic [SYNC_STAGES-1:0] step_sync_q;
    // Shifts in ones after reset; its last bit marks the point where the
    // synchronizer outputs start reflecting the real switch levels.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   step_prev_q;
    // Step edges are only accepted once step_s has been seen low after reset,
    // so a switch held high through reset release does not fire a step.
    logic                   step_armed_q;

    state_e      state_q;
    state_e      state_d;
    logic        bp_skip_q;
    logic        bp_skip_d;
    logic [15:0] inst_count_q;
    logic [15:0] inst_count_d;

    logic run_s;
    logic step_s;
    logic primed_s;
    logic step_edge_s;
    logic halt_cond_s;
    logic bp_hit_s;
    logic cpu_en_s;

    assign run_s       = run_sync_q[SYNC_STAGES-1];
    assign step_s      = step_sync_q[SYNC_STAGES-1];
    assign primed_s    = prime_q[SYNC_STAGES-1];
    assign step_edge_s = step_armed_q & step_s & ~step_prev_q;
    assign halt_cond_s = (inst_i == HALT_INST);
    assign bp_hit_s    = bp_en_i & (pc_i == bp_addr_i) & ~bp_skip_q;

    // Switch synchronizers, step edge detector and step arming flop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_sync_q   <= '0;
            step_sync_q  <= '0;
            prime_q      <= '0;
            step_prev_q  <= 1'b0;
            step_armed_q <= 1'b0;
        end else begin
            run_sync_q   <= {run_sync_q[SYNC_STAGES-2:0], run_sw_i};
            step_sync_q  <= {step_sync_q[SYNC_STAGES-2:0], step_sw_i};
            prime_q      <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            step_prev_q  <= step_s;
            step_armed_q <= step_armed_q | (primed_s & ~step_s);
        end
    end

    // Next-state, commit enable and breakpoint-skip logic
    always_comb begin
        state_d   = state_q;
        cpu_en_s  = 1'b0;
        bp_skip_d = bp_skip_q;
        case (state_q)
            ST_IDLE: begin
                if (run_s) begin
                    state_d = ST_RUN;
                end else if (step_edge_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_cond_s) begin
                    state_d = ST_HALT;
                end else if (bp_hit_s) begin
                    // Remember the stop so the resume commits this PC once.
                    state_d   = ST_IDLE;
                    bp_skip_d = 1'b1;
                end else if (!run_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cpu_en_s  = 1'b1;
                    bp_skip_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_STEP: begin
                if (halt_cond_s) begin
                    state_d = ST_HALT;
                end else begin
                    cpu_en_s  = 1'b1;
                    bp_skip_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating committed-instruction counter, next value
    always_comb begin
        inst_count_d = inst_count_q;
        if (cpu_en_s && (inst_count_q != 16'hFFFF)) begin
            inst_count_d = inst_count_q + 16'd1;
        end else begin
            inst_count_d = inst_count_q;
        end
    end

    // State, breakpoint-skip and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            bp_skip_q    <= 1'b0;
            inst_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            bp_skip_q    <= bp_skip_d;
            inst_count_q <= inst_count_d;
        end
    end

    // cpu_en must be combinational: the core commits in the same cycle.
    assign cpu_en_o     = cpu_en_s;
    assign halted_o     = (state_q == ST_HALT);
    assign state_o      = state_q;
    assign inst_count_o = inst_count_q;

endmodule

// File: tb/tb_proc_exec_ctrl.sv
module tb_proc_exec_ctrl;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        run_sw  = 1'b0;
    logic        step_sw = 1'b0;
    logic        bp_en   = 1'b0;
    logic [15:0] bp_addr = 16'h0000;
    logic [15:0] pc      = 16'h0000;
    logic [15:0] inst    = 16'h1234;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] inst_count;

    int   total   = 0;
    int   bad     = 0;
    logic last_en = 1'b0;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    proc_exec_ctrl #(
        .INST_WIDTH (16),
        .HALT_INST  (16'hFFFF),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_sw_i    (run_sw),
        .step_sw_i   (step_sw),
        .bp_en_i     (bp_en),
        .bp_addr_i   (bp_addr),
        .pc_i        (pc),
        .inst_i      (inst),
        .cpu_en_o    (cpu_en),
        .halted_o    (halted),
        .state_o     (state),
        .inst_count_o(inst_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: sample cpu_en before the edge, advance the modelled core PC after it.
    task automatic tick();
        @(negedge clk);
        last_en = cpu_en;
        @(posedge clk);
        #1;
        if (last_en) pc = pc + 16'd1;
        #1;
    endtask

    // Reset with step_sw at the given level; releases 2 time units after a posedge.
    task automatic do_reset(input logic step_lvl);
        rst = 1'b1; run_sw = 1'b0; step_sw = step_lvl; bp_en = 1'b0;
        bp_addr = 16'h0000; pc = 16'h0000; inst = 16'h1234;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst = 1'b1;
        #1;
        total += 4;
        if (state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en: got %0b expected 0", cpu_en); end
        if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        if (inst_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0h expected 0", inst_count); end
        do_reset(1'b0);
        tick(); tick(); tick();
        total++;
        if (state !== S_IDLE || cpu_en !== 1'b0) begin bad++; $display("FAIL reset_idle: state=%0d cpu_en=%0b expected 0/0", state, cpu_en); end
    endtask

    task automatic test_run();
        do_reset(1'b0);
        run_sw = 1'b1;
        tick(); tick();
        total += 2;
        if (state !== S_IDLE) begin bad++; $display("FAIL run_latency: state=%0d expected %0d", state, S_IDLE); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_idle_en: got %0b expected 0", cpu_en); end
        tick();
        total += 3;
        if (state !== S_RUN) begin bad++; $display("FAIL run_enter: state=%0d expected %0d", state, S_RUN); end
        if (cpu_en !== 1'b1) begin bad++; $display("FAIL run_en: got %0b expected 1", cpu_en); end
        if (inst_count !== 16'd0) begin bad++; $display("FAIL run_count0: got %0h expected 0", inst_count); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cpu_en !== 1'b1) begin bad++; $display("FAIL run_cycle%0d: cpu_en=%0b expected 1", i, cpu_en); end
            tick();
        end
        total += 2;
        if (inst_count !== 16'd10) begin bad++; $display("FAIL run_count10: got %0d expected 10", inst_count); end
        if (pc !== 16'd10) begin bad++; $display("FAIL run_pc10: got %0d expected 10", pc); end
        run_sw = 1'b0;
        tick(); tick();
        total += 2;
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_stop_en: got %0b expected 0", cpu_en); end
        if (state !== S_RUN) begin bad++; $display("FAIL run_stop_state: state=%0d expected %0d", state, S_RUN); end
        tick();
        total += 2;
        if (state !== S_IDLE) begin bad++; $display("FAIL run_to_idle: state=%0d expected %0d", state, S_IDLE); end
        if (inst_count !== 16'd12) begin bad++; $display("FAIL run_count12: got %0d expected 12", inst_count); end
    endtask

    task automatic test_step();
        int en_cnt;
        do_reset(1'b0);
        repeat (4) tick();
        for (int p = 0; p < 3; p++) begin
            en_cnt = 0;
            step_sw = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (c == 4) step_sw = 1'b0;
                tick();
                en_cnt += int'(last_en);
            end
            total += 2;
            if (en_cnt != 1) begin bad++; $display("FAIL step_pulse%0d: enable cycles=%0d expected 1", p, en_cnt); end
            if (state !== S_IDLE) begin bad++; $display("FAIL step_idle%0d: state=%0d expected %0d", p, state, S_IDLE); end
        end
        total += 2;
        if (inst_count !== 16'd3) begin bad++; $display("FAIL step_count: got %0d expected 3", inst_count); end
        if (pc !== 16'd3) begin bad++; $display("FAIL step_pc: got %0d expected 3", pc); end
    endtask

    task automatic test_step_held_reset();
        int en_cnt;
        do_reset(1'b1);
        en_cnt = 0;
        repeat (8) begin tick(); en_cnt += int'(last_en); end
        total += 2;
        if (en_cnt != 0) begin bad++; $display("FAIL held_step_en: enable cycles=%0d expected 0", en_cnt); end
        if (state !== S_IDLE || inst_count !== 16'd0) begin bad++; $display("FAIL held_step_state: state=%0d count=%0d expected 0/0", state, inst_count); end
        step_sw = 1'b0;
        repeat (4) tick();
        step_sw = 1'b1;
        en_cnt = 0;
        repeat (8) begin tick(); en_cnt += int'(last_en); end
        step_sw = 1'b0;
        total++;
        if (en_cnt != 1 || inst_count !== 16'd1) begin bad++; $display("FAIL held_step_rearm: enable cycles=%0d count=%0d expected 1/1", en_cnt, inst_count); end
    endtask

    task automatic test_breakpoint();
        do_reset(1'b0);
        bp_en = 1'b1; bp_addr = 16'h0004; run_sw = 1'b1;
        repeat (3) tick();
        repeat (3) tick();
        run_sw = 1'b0;
        tick();
        total += 3;
        if (pc !== 16'd4) begin bad++; $display("FAIL bp_reach_pc: got %0d expected 4", pc); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL bp_hit_en: got %0b expected 0", cpu_en); end
        if (state !== S_RUN) begin bad++; $display("FAIL bp_hit_state: state=%0d expected %0d", state, S_RUN); end
        tick();
        total += 3;
        if (state !== S_IDLE) begin bad++; $display("FAIL bp_stop_state: state=%0d expected %0d", state, S_IDLE); end
        if (pc !== 16'd4) begin bad++; $display("FAIL bp_stop_pc: got %0d expected 4", pc); end
        if (inst_count !== 16'd4) begin bad++; $display("FAIL bp_stop_count: got %0d expected 4", inst_count); end
        step_sw = 1'b1;
        repeat (3) tick();
        total += 2;
        if (state !== S_STEP) begin bad++; $display("FAIL bp_step_state: state=%0d expected %0d", state, S_STEP); end
        if (cpu_en !== 1'b1 || pc !== 16'd4) begin bad++; $display("FAIL bp_step_commit: cpu_en=%0b pc=%0d expected 1/4", cpu_en, pc); end
        tick();
        step_sw = 1'b0;
        total += 2;
        if (state !== S_IDLE) begin bad++; $display("FAIL bp_step_idle: state=%0d expected %0d", state, S_IDLE); end
        if (pc !== 16'd5 || inst_count !== 16'd5) begin bad++; $display("FAIL bp_step_count: pc=%0d count=%0d expected 5/5", pc, inst_count); end
        // Skip must be consumed: revisiting the breakpoint stops again.
        pc = 16'h0004;
        run_sw = 1'b1;
        repeat (3) tick();
        total++;
        if (state !== S_RUN || cpu_en !== 1'b0) begin bad++; $display("FAIL bp_rehit: state=%0d cpu_en=%0b expected 1/0", state, cpu_en); end
    endtask

    task automatic test_halt();
        do_reset(1'b0);
        run_sw = 1'b1;
        repeat (3) tick();
        repeat (2) tick();
        inst = 16'hFFFF;
        #1;
        total += 2;
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_en: got %0b expected 0", cpu_en); end
        if (state !== S_RUN) begin bad++; $display("FAIL halt_pre_state: state=%0d expected %0d", state, S_RUN); end
        tick();
        total += 3;
        if (state !== S_HALT || halted !== 1'b1) begin bad++; $display("FAIL halt_state: state=%0d halted=%0b expected 3/1", state, halted); end
        if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_hold_en: got %0b expected 0", cpu_en); end
        if (inst_count !== 16'd2) begin bad++; $display("FAIL halt_count: got %0d expected 2", inst_count); end
        inst = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            run_sw = (i % 2 == 0) ? 1'b0 : 1'b1;
            step_sw = (i % 4 < 2) ? 1'b1 : 1'b0;
            tick();
            total++;
            if (state !== S_HALT || cpu_en !== 1'b0) begin bad++; $display("FAIL halt_sticky%0d: state=%0d cpu_en=%0b expected 3/0", i, state, cpu_en); end
        end
        #1;
        rst = 1'b1;
        #1;
        total += 2;
        if (state !== S_IDLE || halted !== 1'b0) begin bad++; $display("FAIL halt_reset_state: state=%0d halted=%0b expected 0/0", state, halted); end
        if (inst_count !== 16'd0) begin bad++; $display("FAIL halt_reset_count: got %0d expected 0", inst_count); end
    endtask

    task automatic test_step_halt();
        do_reset(1'b0);
        repeat (4) tick();
        inst = 16'hFFFF;
        step_sw = 1'b1;
        repeat (3) tick();
        total++;
        if (state !== S_STEP || cpu_en !== 1'b0) begin bad++; $display("FAIL step_halt_en: state=%0d cpu_en=%0b expected 2/0", state, cpu_en); end
        tick();
        step_sw = 1'b0;
        total++;
        if (state !== S_HALT || inst_count !== 16'd0) begin bad++; $display("FAIL step_halt_state: state=%0d count=%0d expected 3/0", state, inst_count); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        run_sw = 1'b1;
        repeat (6) tick();
        total++;
        if (inst_count !== 16'd3 || cpu_en !== 1'b1) begin bad++; $display("FAIL async_pre: count=%0d cpu_en=%0b expected 3/1", inst_count, cpu_en); end
        #1;
        rst = 1'b1;
        #1;
        total += 2;
        if (cpu_en !== 1'b0 || state !== S_IDLE) begin bad++; $display("FAIL async_en: cpu_en=%0b state=%0d expected 0/0", cpu_en, state); end
        if (inst_count !== 16'd0) begin bad++; $display("FAIL async_count: got %0d expected 0", inst_count); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick(); tick();
        total++;
        if (state !== S_IDLE || cpu_en !== 1'b0) begin bad++; $display("FAIL async_restart_wait: state=%0d cpu_en=%0b expected 0/0", state, cpu_en); end
        tick();
        total++;
        if (state !== S_RUN) begin bad++; $display("FAIL async_restart: state=%0d expected %0d", state, S_RUN); end
    endtask

    task automatic test_saturate();
        do_reset(1'b0);
        run_sw = 1'b1;
        repeat (3) tick();
        repeat (65534) tick();
        total++;
        if (inst_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: got %0h expected fffe", inst_count); end
        tick();
        total++;
        if (inst_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %0h expected ffff", inst_count); end
        repeat (4) tick();
        total += 2;
        if (inst_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h expected ffff", inst_count); end
        if (cpu_en !== 1'b1) begin bad++; $display("FAIL sat_en: got %0b expected 1", cpu_en); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_step_held_reset();
        test_breakpoint();
        test_halt();
        test_step_halt();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
